mul_issue_ctrl: RTL and testbench
=================================

// Module: mul_issue_ctrl
// PURPOSE
//  Initiator for the multiplier handshake (inready/invalid/flush/outvalid). Takes RV32M MUL-class ops
//  from the execute stage, decodes signedness, issues one multiply, captures the product, returns
//  the selected XLEN half to writeback over valid/ready. Sits between issue logic and the multiplier.
// PARAMETERS
//  XLEN      32  operand/result width
//  TAG_W     5   width of the request tag (destination register) carried through unchanged
// PORTS
//  clk            in   1      clock
//  rst            in   1      synchronous active-high reset
//  req_valid      in   1      request present
//  req_ready      out  1      block can accept a request
//  req_op         in   2      00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//  req_rs1        in   XLEN   multiplicand
//  req_rs2        in   XLEN   multiplier
//  req_tag        in   TAG_W  opaque tag
//  flush          in   1      pipeline kill
//  mul_inready    in   1      multiplier idle
//  mul_invalid    out  1      issue strobe to multiplier
//  mul_signed     out  2      [1] rs1 signed, [0] rs2 signed
//  mul_a, mul_b   out  XLEN   operands to multiplier
//  mul_flush      out  1      abort strobe to multiplier
//  mul_outvalid   in   1      product valid (one-cycle pulse)
//  mul_result_hi  in   XLEN   product [2XLEN-1:XLEN]
//  mul_result_lo  in   XLEN   product [XLEN-1:0]
//  resp_valid     out  1      result present
//  resp_ready     in   1      writeback accepts
//  resp_data      out  XLEN   selected half
//  resp_tag       out  TAG_W  tag of the request
// BEHAVIOUR
//  - Reset: FSM=IDLE; req_ready=1; mul_invalid=0; mul_flush=0; resp_valid=0; all data regs 0.
//  - FSM: IDLE -> ISSUE on req accept (req_valid&req_ready&!flush). ISSUE: mul_invalid=mul_inready,
//    -> WAIT when mul_inready=1, else stay. WAIT -> RESP on mul_outvalid. RESP -> IDLE on resp_ready.
//    DRAIN: wait for mul_inready=1 -> IDLE.
//  - req_ready=1 only in IDLE. Operands, mul_signed and tag are registered on accept and held stable
//    through ISSUE and WAIT.
//  - Decode: MUL->signed 11, lo half; MULH->11, hi; MULHSU->10, hi; MULHU->00, hi.
//  - Product latched on mul_outvalid; resp_data/resp_tag stable while resp_valid=1 and !resp_ready.
//  - Latency: accept at cycle 0, mul_invalid at cycle 1 (when mul_inready=1), resp_valid the cycle
//    after mul_outvalid.
//  - flush: in ISSUE -> IDLE, nothing issued. In WAIT -> one-cycle mul_flush, -> DRAIN.
//    In RESP -> resp_valid drops next cycle, -> IDLE. In IDLE: the request is not accepted.
//  - Simultaneous flush and mul_outvalid in WAIT: flush wins, product discarded, -> DRAIN.
//  - rst mid-operation: immediate return to reset values. The multiplier shares rst.
//  - At most one multiply outstanding.
// CONFIGURATION
//  MUL_ISSUE_REUSE_EN defined: keep the last full product plus rs1/rs2/mul_signed and a valid bit.
//    An accepted request hits when rs1 and rs2 match and (op==MUL, or mul_signed matches).
//    A hit skips ISSUE/WAIT and goes straight to RESP, so resp_valid is the cycle after accept.
//    Flush or rst clears the valid bit.
//  Not defined: every request goes through the multiplier; no extra storage.
// STRUCTURE
//  mul_pkg: op encodings (MUL_OP_*), FSM state localparams (IDLE/ISSUE/WAIT/RESP/DRAIN),
//    signedness constants.
//  Sub-module mul_op_decode (combinational): op -> {mul_signed, sel_hi}.
// TESTING
//  1. MULHU 0xFFFFFFFF*0xFFFFFFFF -> signed=00, resp_data=0xFFFFFFFE, tag echoed.
//  2. MULH 0xFFFFFFFF*0x00000002 -> 0xFFFFFFFF. MULHSU same operands -> 0xFFFFFFFF.
//     MUL same operands -> 0xFFFFFFFE.
//  3. flush 2 cycles into WAIT -> one-cycle mul_flush, no resp_valid. req_ready=1 once mul_inready=1.
//  4. resp_ready low for 5 cycles -> resp_valid/data held; req_ready=0 throughout.
//  5. flush coincident with mul_outvalid -> no response, FSM goes to DRAIN.
//  6. (REUSE_EN) MULH 7*-3 then MUL 7*-3 -> second resp_valid 1 cycle after accept, no mul_invalid,
//     data 0xFFFFFFEB.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared encodings for the multiplier issue controller: op codes, FSM states
// and operand signedness selections.
package mul_pkg;

  localparam logic [1:0] MUL_OP_MUL    = 2'b00;
  localparam logic [1:0] MUL_OP_MULH   = 2'b01;
  localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
  localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

  // {rs1 signed, rs2 signed}
  localparam logic [1:0] MUL_SGN_SS = 2'b11;
  localparam logic [1:0] MUL_SGN_SU = 2'b10;
  localparam logic [1:0] MUL_SGN_UU = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_DRAIN = 3'd4
  } mul_state_e;

endpackage

// File: rtl/mul_op_decode.sv
// Combinational RV32M MUL-class decode: op -> operand signedness and which
// product half is returned.
module mul_op_decode
  import mul_pkg::*;
(
  input  logic [1:0] op,
  output logic [1:0] mul_signed,
  output logic       sel_hi
);

  // Op to signedness / half-select lookup
  always_comb begin
    mul_signed = MUL_SGN_SS;
    sel_hi     = 1'b0;
    case (op)
      MUL_OP_MUL: begin
        mul_signed = MUL_SGN_SS;
        sel_hi     = 1'b0;
      end
      MUL_OP_MULH: begin
        mul_signed = MUL_SGN_SS;
        sel_hi     = 1'b1;
      end
      MUL_OP_MULHSU: begin
        mul_signed = MUL_SGN_SU;
        sel_hi     = 1'b1;
      end
      MUL_OP_MULHU: begin
        mul_signed = MUL_SGN_UU;
        sel_hi     = 1'b1;
      end
      default: begin
        mul_signed = MUL_SGN_SS;
        sel_hi     = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mul_issue_ctrl.sv
// Issue controller for a handshaked multiplier: one multiply outstanding,
// selected product half returned over valid/ready. Optional MUL_ISSUE_REUSE_EN.
module mul_issue_ctrl
  import mul_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [XLEN-1:0]  req_rs1,
  input  logic [XLEN-1:0]  req_rs2,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  input  logic             mul_inready,
  output logic             mul_invalid,
  output logic [1:0]       mul_signed,
  output logic [XLEN-1:0]  mul_a,
  output logic [XLEN-1:0]  mul_b,
  output logic             mul_flush,
  input  logic             mul_outvalid,
  input  logic [XLEN-1:0]  mul_result_hi,
  input  logic [XLEN-1:0]  mul_result_lo,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [XLEN-1:0]  resp_data,
  output logic [TAG_W-1:0] resp_tag
);

  mul_state_e       state_q, state_d;
  logic [XLEN-1:0]  a_q, a_d;
  logic [XLEN-1:0]  b_q, b_d;
  logic [1:0]       signed_q, signed_d;
  logic             sel_hi_q, sel_hi_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [XLEN-1:0]  resp_data_q, resp_data_d;
  logic             mul_invalid_s;
  logic             mul_flush_s;
  logic [1:0]       dec_signed_s;
  logic             dec_sel_hi_s;

`ifdef MUL_ISSUE_REUSE_EN
  logic [XLEN-1:0]  cache_hi_q, cache_hi_d;
  logic [XLEN-1:0]  cache_lo_q, cache_lo_d;
  logic [XLEN-1:0]  cache_a_q, cache_a_d;
  logic [XLEN-1:0]  cache_b_q, cache_b_d;
  logic [1:0]       cache_signed_q, cache_signed_d;
  logic             cache_valid_q, cache_valid_d;
  logic             hit_s;
`endif

  mul_op_decode u_decode (
    .op         (req_op),
    .mul_signed (dec_signed_s),
    .sel_hi     (dec_sel_hi_s)
  );

`ifdef MUL_ISSUE_REUSE_EN
  // Low half does not depend on signedness, so MUL hits on operands alone
  always_comb begin
    hit_s = cache_valid_q && (req_rs1 == cache_a_q) && (req_rs2 == cache_b_q) &&
            ((req_op == MUL_OP_MUL) || (dec_signed_s == cache_signed_q));
  end
`endif

  // Next-state, capture and strobe logic
  always_comb begin
    state_d       = state_q;
    a_d           = a_q;
    b_d           = b_q;
    signed_d      = signed_q;
    sel_hi_d      = sel_hi_q;
    tag_d         = tag_q;
    resp_data_d   = resp_data_q;
    mul_invalid_s = 1'b0;
    mul_flush_s   = 1'b0;
`ifdef MUL_ISSUE_REUSE_EN
    cache_hi_d     = cache_hi_q;
    cache_lo_d     = cache_lo_q;
    cache_a_d      = cache_a_q;
    cache_b_d      = cache_b_q;
    cache_signed_d = cache_signed_q;
    cache_valid_d  = cache_valid_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid && !flush) begin
          a_d      = req_rs1;
          b_d      = req_rs2;
          signed_d = dec_signed_s;
          sel_hi_d = dec_sel_hi_s;
          tag_d    = req_tag;
          state_d  = ST_ISSUE;
`ifdef MUL_ISSUE_REUSE_EN
          if (hit_s) begin
            resp_data_d = dec_sel_hi_s ? cache_hi_q : cache_lo_q;
            state_d     = ST_RESP;
          end else begin
            resp_data_d = resp_data_q;
          end
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (mul_inready) begin
          mul_invalid_s = 1'b1;
          state_d       = ST_WAIT;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        // flush beats a coincident product: the product is dropped
        if (flush) begin
          mul_flush_s = 1'b1;
          state_d     = ST_DRAIN;
        end else if (mul_outvalid) begin
          resp_data_d = sel_hi_q ? mul_result_hi : mul_result_lo;
          state_d     = ST_RESP;
`ifdef MUL_ISSUE_REUSE_EN
          cache_hi_d     = mul_result_hi;
          cache_lo_d     = mul_result_lo;
          cache_a_d      = a_q;
          cache_b_d      = b_q;
          cache_signed_d = signed_q;
          cache_valid_d  = 1'b1;
`endif
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (flush || resp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      ST_DRAIN: begin
        if (mul_inready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
`ifdef MUL_ISSUE_REUSE_EN
    if (flush) begin
      cache_valid_d = 1'b0;
    end else begin
      cache_valid_d = cache_valid_d;
    end
`endif
  end

  // State and data registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      signed_q    <= 2'b00;
      sel_hi_q    <= 1'b0;
      tag_q       <= '0;
      resp_data_q <= '0;
`ifdef MUL_ISSUE_REUSE_EN
      cache_hi_q     <= '0;
      cache_lo_q     <= '0;
      cache_a_q      <= '0;
      cache_b_q      <= '0;
      cache_signed_q <= 2'b00;
      cache_valid_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      signed_q    <= signed_d;
      sel_hi_q    <= sel_hi_d;
      tag_q       <= tag_d;
      resp_data_q <= resp_data_d;
`ifdef MUL_ISSUE_REUSE_EN
      cache_hi_q     <= cache_hi_d;
      cache_lo_q     <= cache_lo_d;
      cache_a_q      <= cache_a_d;
      cache_b_q      <= cache_b_d;
      cache_signed_q <= cache_signed_d;
      cache_valid_q  <= cache_valid_d;
`endif
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign resp_valid  = (state_q == ST_RESP);
  assign mul_invalid = mul_invalid_s;
  assign mul_flush   = mul_flush_s;
  assign mul_signed  = signed_q;
  assign mul_a       = a_q;
  assign mul_b       = b_q;
  assign resp_data   = resp_data_q;
  assign resp_tag    = tag_q;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Directed bench for mul_issue_ctrl; the multiplier side is driven by hand
// with precomputed products. Reuse-hit step runs only with MUL_ISSUE_REUSE_EN.
module tb_mul_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_rs1, req_rs2;
  logic [4:0]  req_tag;
  logic        flush;
  logic        mul_inready;
  logic        mul_invalid;
  logic [1:0]  mul_signed;
  logic [31:0] mul_a, mul_b;
  logic        mul_flush;
  logic        mul_outvalid;
  logic [31:0] mul_result_hi, mul_result_lo;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [4:0]  resp_tag;

  int n_cmp  = 0;
  int n_fail = 0;

  mul_issue_ctrl #(.XLEN(32), .TAG_W(5)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_tag(req_tag),
    .flush(flush), .mul_inready(mul_inready), .mul_invalid(mul_invalid),
    .mul_signed(mul_signed), .mul_a(mul_a), .mul_b(mul_b), .mul_flush(mul_flush),
    .mul_outvalid(mul_outvalid), .mul_result_hi(mul_result_hi),
    .mul_result_lo(mul_result_lo), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_tag(resp_tag)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Full transaction with an immediately ready multiplier and writeback
  task automatic do_mul(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag,
                        input logic [31:0] hi, input logic [31:0] lo,
                        input logic [1:0] exp_sgn, input logic [31:0] exp_data);
    req_valid = 1'b1; req_op = op; req_rs1 = a; req_rs2 = b; req_tag = tag;
    mul_inready = 1'b1;
    #1 chk({name, ".req_ready"}, {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0; req_rs1 = 32'h0; req_rs2 = 32'h0;
    #1;
    chk({name, ".invalid"}, {31'd0, mul_invalid}, 32'd1);
    chk({name, ".signed"}, {30'd0, mul_signed}, {30'd0, exp_sgn});
    chk({name, ".a"}, mul_a, a);
    chk({name, ".b"}, mul_b, b);
    tick();
    mul_inready = 1'b0; mul_outvalid = 1'b1; mul_result_hi = hi; mul_result_lo = lo;
    #1 chk({name, ".early_resp"}, {31'd0, resp_valid}, 32'd0);
    tick();
    mul_outvalid = 1'b0; mul_inready = 1'b1; resp_ready = 1'b1;
    mul_result_hi = 32'h0; mul_result_lo = 32'h0;
    #1;
    chk({name, ".resp_valid"}, {31'd0, resp_valid}, 32'd1);
    chk({name, ".data"}, resp_data, exp_data);
    chk({name, ".tag"}, {27'd0, resp_tag}, {27'd0, tag});
    tick();
    resp_ready = 1'b0;
    #1;
    chk({name, ".done_valid"}, {31'd0, resp_valid}, 32'd0);
    chk({name, ".done_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  // Flush while idle with a request present: not accepted, reuse state cleared
  task automatic flush_idle(input string name);
    req_valid = 1'b1; req_op = 2'b00; req_rs1 = 32'h1; req_rs2 = 32'h1; flush = 1'b1;
    tick();
    req_valid = 1'b0; flush = 1'b0;
    #1;
    chk({name, ".ready"}, {31'd0, req_ready}, 32'd1);
    chk({name, ".noissue"}, {31'd0, mul_invalid}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_rs1 = 32'h0; req_rs2 = 32'h0;
    req_tag = 5'd0; flush = 1'b0; mul_inready = 1'b1; mul_outvalid = 1'b0;
    mul_result_hi = 32'h0; mul_result_lo = 32'h0; resp_ready = 1'b0;
    tick(); tick();
    chk("rst.req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst.invalid", {31'd0, mul_invalid}, 32'd0);
    chk("rst.flush", {31'd0, mul_flush}, 32'd0);
    chk("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst.resp_data", resp_data, 32'h0);
    chk("rst.resp_tag", {27'd0, resp_tag}, 32'd0);
    rst = 1'b0;
    tick();

    // 1/2: decode and half selection
    do_mul("mulhu", 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd17, 32'hFFFFFFFE, 32'h00000001,
           2'b00, 32'hFFFFFFFE);
    do_mul("mulh", 2'b01, 32'hFFFFFFFF, 32'h00000002, 5'd3, 32'hFFFFFFFF, 32'hFFFFFFFE,
           2'b11, 32'hFFFFFFFF);
    do_mul("mulhsu", 2'b10, 32'hFFFFFFFF, 32'h00000002, 5'd4, 32'hFFFFFFFF, 32'hFFFFFFFE,
           2'b10, 32'hFFFFFFFF);
    flush_idle("fl_idle");
    do_mul("mul", 2'b00, 32'hFFFFFFFF, 32'h00000002, 5'd5, 32'hFFFFFFFF, 32'hFFFFFFFE,
           2'b11, 32'hFFFFFFFE);

    // 3: flush two cycles into WAIT
    req_valid = 1'b1; req_op = 2'b00; req_rs1 = 32'd3; req_rs2 = 32'd5; req_tag = 5'd6;
    tick();
    req_valid = 1'b0;
    tick();
    mul_inready = 1'b0;
    tick();
    flush = 1'b1;
    #1 chk("wflush.strobe", {31'd0, mul_flush}, 32'd1);
    tick();
    flush = 1'b0;
    #1;
    chk("wflush.one_cycle", {31'd0, mul_flush}, 32'd0);
    chk("wflush.no_resp", {31'd0, resp_valid}, 32'd0);
    chk("wflush.drain", {31'd0, req_ready}, 32'd0);
    tick();
    mul_inready = 1'b1;
    #1 chk("wflush.still_drain", {31'd0, req_ready}, 32'd0);
    tick();
    #1 chk("wflush.idle", {31'd0, req_ready}, 32'd1);

    // 4: stall in ISSUE, then backpressured response
    req_valid = 1'b1; req_op = 2'b11; req_rs1 = 32'h00010000; req_rs2 = 32'h00010000;
    req_tag = 5'd9; mul_inready = 1'b0;
    tick();
    req_valid = 1'b0;
    #1 chk("stall.no_issue", {31'd0, mul_invalid}, 32'd0);
    tick();
    mul_inready = 1'b1;
    #1;
    chk("stall.issue", {31'd0, mul_invalid}, 32'd1);
    chk("stall.a", mul_a, 32'h00010000);
    tick();
    mul_inready = 1'b0; mul_outvalid = 1'b1; mul_result_hi = 32'h1; mul_result_lo = 32'h0;
    tick();
    mul_outvalid = 1'b0; mul_inready = 1'b1; mul_result_hi = 32'h0;
    #1 chk("hold.first", resp_data, 32'h1);
    for (int i = 0; i < 5; i++) begin
      tick();
      #1;
      chk("hold.valid", {31'd0, resp_valid}, 32'd1);
      chk("hold.data", resp_data, 32'h1);
      chk("hold.tag", {27'd0, resp_tag}, 32'd9);
      chk("hold.req_ready", {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    #1 chk("hold.release", {31'd0, resp_valid}, 32'd0);

    // 5: flush coincident with product
    req_valid = 1'b1; req_op = 2'b00; req_rs1 = 32'd4; req_rs2 = 32'd4; req_tag = 5'd10;
    tick();
    req_valid = 1'b0;
    tick();
    mul_inready = 1'b0; mul_outvalid = 1'b1; mul_result_lo = 32'd16; flush = 1'b1;
    #1 chk("coinc.strobe", {31'd0, mul_flush}, 32'd1);
    tick();
    mul_outvalid = 1'b0; flush = 1'b0; mul_result_lo = 32'h0;
    #1;
    chk("coinc.no_resp", {31'd0, resp_valid}, 32'd0);
    chk("coinc.drain", {31'd0, req_ready}, 32'd0);
    mul_inready = 1'b1;
    tick();
    #1;
    chk("coinc.idle", {31'd0, req_ready}, 32'd1);
    chk("coinc.no_resp2", {31'd0, resp_valid}, 32'd0);

    // flush while in ISSUE: nothing issued
    req_valid = 1'b1; req_rs1 = 32'd8; req_rs2 = 32'd8; mul_inready = 1'b0;
    tick();
    req_valid = 1'b0; mul_inready = 1'b1; flush = 1'b1;
    #1 chk("iflush.no_issue", {31'd0, mul_invalid}, 32'd0);
    tick();
    flush = 1'b0;
    #1 chk("iflush.idle", {31'd0, req_ready}, 32'd1);

    // flush while in RESP
    req_valid = 1'b1; req_op = 2'b00; req_rs1 = 32'd2; req_rs2 = 32'd9; req_tag = 5'd12;
    tick();
    req_valid = 1'b0;
    tick();
    mul_inready = 1'b0; mul_outvalid = 1'b1; mul_result_lo = 32'd18;
    tick();
    mul_outvalid = 1'b0; mul_inready = 1'b1; mul_result_lo = 32'h0; flush = 1'b1;
    #1 chk("rflush.valid", {31'd0, resp_valid}, 32'd1);
    tick();
    flush = 1'b0;
    #1;
    chk("rflush.dropped", {31'd0, resp_valid}, 32'd0);
    chk("rflush.idle", {31'd0, req_ready}, 32'd1);

    // reset mid-operation
    req_valid = 1'b1; req_op = 2'b01; req_rs1 = 32'h55; req_rs2 = 32'h66; req_tag = 5'd21;
    tick();
    req_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mrst.ready", {31'd0, req_ready}, 32'd1);
    chk("mrst.a", mul_a, 32'h0);
    chk("mrst.data", resp_data, 32'h0);
    chk("mrst.tag", {27'd0, resp_tag}, 32'd0);

`ifdef MUL_ISSUE_REUSE_EN
    // 6: MUL after MULH on the same operands reuses the stored product
    do_mul("reuse_mulh", 2'b01, 32'h00000007, 32'hFFFFFFFD, 5'd7, 32'hFFFFFFFF, 32'hFFFFFFEB,
           2'b11, 32'hFFFFFFFF);
    req_valid = 1'b1; req_op = 2'b00; req_rs1 = 32'h00000007; req_rs2 = 32'hFFFFFFFD;
    req_tag = 5'd8;
    tick();
    req_valid = 1'b0;
    #1;
    chk("reuse.no_issue", {31'd0, mul_invalid}, 32'd0);
    chk("reuse.valid", {31'd0, resp_valid}, 32'd1);
    chk("reuse.data", resp_data, 32'hFFFFFFEB);
    chk("reuse.tag", {27'd0, resp_tag}, 32'd8);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    #1 chk("reuse.done", {31'd0, req_ready}, 32'd1);
`endif

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
